// File: rtl/shape_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shape_pkg
//  Purpose  : Shared bitmap geometry, bitmap type and scanner state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package shape_pkg;

    localparam int SHAPE_W = 25;
    localparam int SHAPE_H = 25;
    localparam int COORD_W = 5;

    localparam logic [COORD_W-1:0] c_x_last = COORD_W'(SHAPE_W - 1);
    localparam logic [COORD_W-1:0] c_y_last = COORD_W'(SHAPE_H - 1);

    // Row 0 is the top row; bit SHAPE_W-1 of a row is the leftmost column.
    typedef logic [SHAPE_H-1:0][SHAPE_W-1:0] shape_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // Column counted from the left mapped onto the row's bit index.
    function automatic logic [COORD_W-1:0] col_bit(input logic [COORD_W-1:0] x);
        return c_x_last - x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
//  Module   : raster_counter
//  Purpose  : Left-to-right, top-to-bottom x/y raster position counter.
//  Revision : 1.0  initial release
// ============================================================================
module raster_counter
    import shape_pkg::*;
(
    input  logic               clk,
    input  logic               advance,
    input  logic               clear,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               eol,
    output logic               eof
);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (advance) begin
            if (r_x == c_x_last) begin
                r_x <= '0;
                // Wrapping y at the frame end keeps both counters in range.
                r_y <= (r_y == c_y_last) ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign x   = r_x;
    assign y   = r_y;
    assign eol = (r_x == c_x_last);
    assign eof = (r_x == c_x_last) && (r_y == c_y_last);

endmodule
`default_nettype wire

// File: rtl/shape_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : shape_scanner
//  Purpose  : Snapshots a 25x25 bitmap and streams it pixel by pixel over a
//             valid/ready interface with raster coordinates and framing flags.
//  Revision : 1.0  initial release
// ============================================================================
module shape_scanner
    import shape_pkg::*;
#(
    parameter bit INVERT = 1'b0
)(
    input  logic               clk,
    input  logic               reset,
    input  shape_t             ishapes,
    input  logic               start,
    output logic               busy,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               pix_data,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_eol,
    output logic               pix_eof,
    output logic               done
);

    scan_state_t        r_state;
    shape_t             r_snapshot;
    logic               r_busy;
    logic               r_valid;
    logic               r_done;

    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;
    logic               w_eol;
    logic               w_eof;
    logic               w_handshake;
    logic               w_start_accept;
    logic               w_clear;

    assign w_handshake    = r_valid & pix_ready;
    assign w_start_accept = (r_state == IDLE) & start & ~reset;
    assign w_clear        = reset | w_start_accept;

    raster_counter u_raster (
        .clk     (clk),
        .advance (w_handshake),
        .clear   (w_clear),
        .x       (w_x),
        .y       (w_y),
        .eol     (w_eol),
        .eof     (w_eof)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SCAN;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b1;
                    end
                end
                SCAN: begin
                    if (w_handshake && w_eof) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Snapshot has no reset: its contents only matter after a capture.
    always_ff @(posedge clk) begin
        if (w_start_accept) begin
            r_snapshot <= ishapes;
        end
    end

    assign busy      = r_busy;
    assign pix_valid = r_valid;
    assign done      = r_done;
    assign pix_x     = r_valid ? w_x : '0;
    assign pix_y     = r_valid ? w_y : '0;
    assign pix_eol   = r_valid & w_eol;
    assign pix_eof   = r_valid & w_eof;
    assign pix_data  = r_valid ? (r_snapshot[w_y][col_bit(w_x)] ^ INVERT) : INVERT;

endmodule
`default_nettype wire

// File: doc/shape_scanner.md
SHAPE_SCANNER -- requirements
Module: shape_scanner

Interface
REQ-001 The block SHALL have one clock and reset SHALL be synchronous and active-high.
REQ-002 Parameter INVERT, default 0, meaning: when 1, every emitted pixel bit is the complement of the stored bit.
REQ-003 Port clk, input, 1 bit, meaning: the single clock.
REQ-004 Port reset, input, 1 bit, meaning: synchronous, active-high reset.
REQ-005 Port ishapes, input, 25 rows x 25 bits, meaning: the shape bitmap; row index 0 is the top row, and bit 24 of each row is the leftmost column.
REQ-006 Port start, input, 1 bit, meaning: a request to capture ishapes and begin a scan.
REQ-007 Port busy, output, 1 bit, meaning: a scan is in progress.
REQ-008 Port pix_valid, output, 1 bit, meaning: a pixel is offered.
REQ-009 Port pix_ready, input, 1 bit, meaning: the downstream stage accepts the offered pixel.
REQ-010 Port pix_data, output, 1 bit, meaning: the pixel value (1 = background, 0 = mark, before INVERT).
REQ-011 Port pix_x, output, 5 bits, meaning: the column, 0..24, counted from the left.
REQ-012 Port pix_y, output, 5 bits, meaning: the row, 0..24, counted from the top.
REQ-013 Port pix_eol, output, 1 bit, meaning: the current pixel is the last in its row (pix_x == 24).
REQ-014 Port pix_eof, output, 1 bit, meaning: the current pixel is the last of the frame (x == 24 and y == 24).
REQ-015 Port done, output, 1 bit, meaning: a one-cycle pulse after the final pixel is accepted.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and SCAN.
REQ-017 In IDLE, start SHALL capture all 625 bits of ishapes into an internal snapshot buffer, set x and y to 0, and move to SCAN in the next cycle.
REQ-018 The first pixel (x=0, y=0) SHALL be offered, with pix_valid high, in the cycle after start is sampled (latency 1).
REQ-019 A handshake SHALL occur exactly when pix_valid && pix_ready are both high.
REQ-020 On a handshake, x SHALL increment; at x == 24, x SHALL wrap to 0 and y SHALL increment.
REQ-021 While pix_valid is high and pix_ready is low, pix_data, pix_x, pix_y, pix_eol and pix_eof SHALL hold stable.
REQ-022 pix_valid SHALL never drop before its pixel has been accepted.
REQ-023 pix_data SHALL equal snapshot[y][24-x], XOR INVERT.
REQ-024 Pixels SHALL be read only from the snapshot, so changes on ishapes during SCAN have no effect.
REQ-025 On the handshake at (24,24), the next cycle SHALL have done=1, busy=0, pix_valid=0 and state IDLE.
REQ-026 start while in SCAN SHALL be ignored and SHALL NOT restart the scan.
REQ-027 start in the cycle where done is high SHALL be accepted, because the block is then in IDLE.
REQ-028 busy SHALL be 1 exactly when state == SCAN.
REQ-029 pix_valid SHALL be 1 exactly when state == SCAN.
REQ-030 With pix_ready held at 1, a frame SHALL take 625 consecutive handshake cycles.
REQ-031 x SHALL never exceed 24 and y SHALL never exceed 24.
REQ-032 When not valid, pix_x, pix_y, pix_eol and pix_eof SHALL be driven to 0.

Reset
REQ-033 Reset SHALL force state=IDLE, x=0, y=0, busy=0, pix_valid=0, done=0, pix_eol=0 and pix_eof=0.
REQ-034 The reset value of pix_data SHALL be INVERT.
REQ-035 Reset during SCAN SHALL abort the frame with no done pulse.
REQ-036 start sampled in the same cycle as reset SHALL be ignored.
REQ-037 The contents of the snapshot buffer need not be reset.

Structure
REQ-038 Package shape_pkg SHALL hold SHAPE_W=25, SHAPE_H=25, COORD_W=5, and typedef shape_t (25 rows x 25 bits), shared with the shape ROM modules.
REQ-039 Sub-module raster_counter SHALL hold the x/y counters, with ports: advance input, clear input, x output, y output, eol output, eof output.
REQ-040 shape_scanner SHALL hold the FSM, the snapshot and the pixel mux.

Verification
REQ-041 Load the all-ones bitmap with vertical tally bars of 0 at columns 1, 5, 9, 13 in rows 3..21, pulse start, and hold pix_ready=1 -> valid rises 1 cycle later; the pixel at (x=1, y=3) is 0 and (x=0, y=3) is 1; eol fires 25 times; eof fires once, at (24,24); done fires 626 cycles after start.
REQ-042 Apply random pix_ready with about 50% duty -> outputs stay stable under every stall, exactly 625 handshakes occur, and the pixel sequence matches the stall-free run.
REQ-043 Change ishapes to all-zeros at handshake 100 -> the remaining pixels still match the captured bitmap.
REQ-044 Pulse start again at handshake 300 -> the scan is not restarted, the sequence is unchanged, and there is one done; then pulse start during the done cycle -> the next frame begins with (0,0) on the following cycle.
REQ-045 Assert reset at handshake 400 -> the next cycle has busy=0 and valid=0 and no done is produced; a following start scans from (0,0).
REQ-046 Run with INVERT=1 on the REQ-041 bitmap -> pixel (1,3) is 1 and pixel (0,0) is 0.
